// File: rtl/cache_bus_arbiter_pkg.sv
// Shared encodings for the cache bus arbiter: FSM states, grant values and
// the width of the starvation counter.
package cache_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b11
  } state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/cache_bus_arbiter.sv
// Merges the instruction- and data-cache sram-like ports onto one bridge port,
// one transaction at a time, data first with bounded instruction starvation.
//
// state | meaning
// IDLE  | no transaction; arbitrate among pending requests
// ADDR  | bus_req high, waiting for the bridge to accept the address
// DATA  | address accepted, waiting for the bridge to return data_ok
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE);

  state_t              state;
  logic                grant;
  logic [STARVE_W-1:0] starve_cnt;
  logic                next_grant;
  logic                addr_hit;
  logic                data_hit;

  // Data wins a tie unless instruction has already waited through the limit.
  always_comb begin
    next_grant = GRANT_INST;
    if (data_req && !(inst_req && (starve_cnt == STARVE_LIMIT)))
      next_grant = GRANT_DATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= GRANT_INST;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            grant <= next_grant;
            state <= ADDR;
            if (next_grant == GRANT_INST)
              starve_cnt <= '0;
            else if (inst_req && (starve_cnt != STARVE_LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ADDR: begin
          if (bus_addr_ok)
            state <= bus_data_ok ? IDLE : DATA;
        end
        DATA: begin
          if (bus_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_req   = (state == ADDR);
  assign bus_wr    = (grant == GRANT_DATA) ? data_wr    : inst_wr;
  assign bus_size  = (grant == GRANT_DATA) ? data_size  : inst_size;
  assign bus_addr  = (grant == GRANT_DATA) ? data_addr  : inst_addr;
  assign bus_wdata = (grant == GRANT_DATA) ? data_wdata : inst_wdata;

  // A data_ok seen in IDLE belongs to nobody and is dropped here.
  assign addr_hit = (state == ADDR) && bus_addr_ok;
  assign data_hit = (addr_hit && bus_data_ok) || ((state == DATA) && bus_data_ok);

  assign inst_addr_ok = addr_hit && (grant == GRANT_INST);
  assign data_addr_ok = addr_hit && (grant == GRANT_DATA);
  assign inst_data_ok = data_hit && (grant == GRANT_INST);
  assign data_data_ok = data_hit && (grant == GRANT_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a bridge model driven step by step,
// with a response scoreboard checked whenever a master sees data_ok.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  typedef struct {
    bit          m;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.MAX_STARVE(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic all_oks_zero(input string tag);
    chk(tag, {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
  endtask

  // Entry: an IDLE cycle with requests already driven. Exit: the IDLE cycle
  // after completion (time = posedge + 1).
  task automatic transact(input bit m, input logic [31:0] addr, input bit ewr,
                          input logic [1:0] esize, input logic [31:0] ewdata,
                          input int aw, input int dw, input bit same,
                          input bit drop, input logic [31:0] rd);
    @(negedge clk);
    chk("idle_bus_req", bus_req, 1'b0);
    cyc();
    for (int i = 0; i < aw; i++) begin
      @(negedge clk);
      chk("addr_wait_bus_req", bus_req, 1'b1);
      all_oks_zero("addr_wait_oks");
      cyc();
    end
    bus_addr_ok = 1'b1;
    if (same) begin
      bus_data_ok = 1'b1;
      bus_rdata   = rd;
      sb.push_back('{m: m, rdata: rd});
    end
    @(negedge clk);
    chk("addr_bus_req", bus_req, 1'b1);
    chk("bus_addr", bus_addr, addr);
    chk("bus_wr", bus_wr, ewr);
    chk("bus_size", bus_size, esize);
    chk("bus_wdata", bus_wdata, ewdata);
    chk("granted_addr_ok", m ? data_addr_ok : inst_addr_ok, 1'b1);
    chk("other_addr_ok", m ? inst_addr_ok : data_addr_ok, 1'b0);
    cyc();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (drop) begin
      if (m) data_req = 1'b0;
      else   inst_req = 1'b0;
    end
    if (!same) begin
      for (int i = 0; i < dw; i++) begin
        @(negedge clk);
        chk("data_wait_bus_req", bus_req, 1'b0);
        all_oks_zero("data_wait_oks");
        cyc();
      end
      bus_data_ok = 1'b1;
      bus_rdata   = rd;
      sb.push_back('{m: m, rdata: rd});
      @(negedge clk);
      chk("data_phase_bus_req", bus_req, 1'b0);
      cyc();
      bus_data_ok = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    bus_rdata = '0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (inst_data_ok || data_data_ok) begin
          if (sb.size() == 0) begin
            chk("unexpected_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_master_ok", e.m ? data_data_ok : inst_data_ok, 1'b1);
            chk("resp_other_ok", e.m ? inst_data_ok : data_data_ok, 1'b0);
            chk("resp_rdata", e.m ? data_rdata : inst_rdata, e.rdata);
          end
        end
      end
    join_none

    cyc();
    @(negedge clk);
    chk("reset_bus_req", bus_req, 1'b0);
    all_oks_zero("reset_oks");
    chk("reset_starve", dut.starve_cnt, 4'd0);
    cyc();
    resetn = 1'b1;

    // instruction-only read
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    transact(1'b0, 32'hBFC0_0000, 1'b0, 2'd2, 32'h0, 1, 1, 1'b0, 1'b1, 32'h3C08_0001);

    // simultaneous: data write first, then instruction after an idle cycle
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
    transact(1'b1, 32'h8000_0010, 1'b1, 2'd2, 32'h1234_5678, 0, 1, 1'b0, 1'b1, 32'h0000_0000);
    chk("starve_after_data", dut.starve_cnt, 4'd1);
    transact(1'b0, 32'hBFC0_0004, 1'b0, 2'd2, 32'h0, 0, 0, 1'b0, 1'b1, 32'h0000_0042);
    chk("starve_after_inst", dut.starve_cnt, 4'd0);

    // addr_ok and data_ok together in the first ADDR cycle
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1;
    data_addr = 32'h8000_0020; data_wdata = 32'h0;
    transact(1'b1, 32'h8000_0020, 1'b0, 2'd1, 32'h0, 0, 0, 1'b1, 1'b1, 32'hA5A5_0001);
    @(negedge clk);
    chk("same_cycle_back_idle", bus_req, 1'b0);
    cyc();

    // stray data_ok in IDLE reaches nobody
    bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    all_oks_zero("idle_stray_data_ok");
    cyc();
    bus_data_ok = 1'b0;

    // starvation: four data grants, then instruction wins
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h8000_0100;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    for (int k = 0; k < 4; k++) begin
      chk("starve_count", dut.starve_cnt, 32'(k));
      transact(1'b1, 32'h8000_0100, 1'b0, 2'd0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0000_1000 + 32'(k));
    end
    chk("starve_saturated", dut.starve_cnt, 4'd4);
    transact(1'b0, 32'hBFC0_0008, 1'b0, 2'd2, 32'h0, 0, 0, 1'b0, 1'b1, 32'h2400_0005);
    chk("starve_cleared", dut.starve_cnt, 4'd0);
    transact(1'b1, 32'h8000_0100, 1'b0, 2'd0, 32'h0, 1, 0, 1'b0, 1'b1, 32'h0000_2000);
    chk("starve_no_inst_wait", dut.starve_cnt, 4'd0);

    // reset while a data read waits in DATA
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0200;
    inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
    @(negedge clk);
    chk("rst_test_idle", bus_req, 1'b0);
    cyc();
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("rst_test_data_addr_ok", data_addr_ok, 1'b1);
    cyc();
    bus_addr_ok = 1'b0; data_req = 1'b0;
    cyc();
    chk("rst_test_starve_before", dut.starve_cnt, 4'd1);
    resetn = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_immediate_bus_req", bus_req, 1'b0);
    all_oks_zero("rst_immediate_oks");
    cyc();
    chk("rst_held_bus_req", bus_req, 1'b0);
    all_oks_zero("rst_held_oks");
    chk("rst_held_starve", dut.starve_cnt, 4'd0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    resetn = 1'b1;
    transact(1'b0, 32'hBFC0_000C, 1'b0, 2'd2, 32'h0, 1, 1, 1'b0, 1'b1, 32'h0000_00C0);
    chk("post_rst_starve", dut.starve_cnt, 4'd0);

    cyc();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
